sample_requester: RTL and testbench
===================================

Name: sample_requester

Overview:
- Consumer-side counterpart of the sine sample generator.
- Issues single-cycle generate_next pulses and captures each returned sample when sample_ready asserts.
- Buffers captured samples in a small FIFO and presents them to the downstream audio output stage (DAC/codec serializer) through a valid/ack pop interface.
- Keeps the FIFO topped up so the output stage never waits on generator latency.

Parameters:
- SAMPLE_W, 16, width of sample data.
- ADDR_W, 2, FIFO address width; DEPTH = 2**ADDR_W (default 4).
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit; used only when REQ_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  allows new requests when high.
- generate_next  output  1  single-cycle request pulse to the sample generator.
- sample_ready  input  1  generator strobe: sample_in is valid this cycle.
- sample_in  input  SAMPLE_W  sample from the generator.
- sample_out  output  SAMPLE_W  FIFO head, first-word fall-through.
- sample_valid  output  1  high when FIFO is non-empty.
- sample_ack  input  1  consumer pops the head this cycle.
- fill_level  output  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- underflow  output  1  sticky: set when an ack arrives while empty.
- timeout_err  output  1  sticky watchdog flag; present only with REQ_TIMEOUT_EN.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE; read/write pointers=0; count=0.
  - generate_next=0, sample_valid=0, fill_level=0, underflow=0, timeout_err=0.
  - sample_out undefined; it is qualified by sample_valid.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ when enable=1 and count < DEPTH. Otherwise stay in IDLE.
  - REQ: generate_next=1 for exactly this one cycle, then -> WAIT unconditionally.
  - WAIT: generate_next=0. On sample_ready=1, write sample_in at the write pointer, increment the write pointer (wraps mod DEPTH), then -> IDLE.
- Request latency:
  - Minimum 1 cycle from entering IDLE to the generate_next pulse.
  - sample_ready is accepted no earlier than the cycle after the pulse.
  - Maximum throughput: one sample per 3 cycles (REQ, WAIT with immediate ready, IDLE).
- Flow control:
  - At most one request outstanding.
  - The FIFO slot is guaranteed free at request time; count < DEPTH is checked in IDLE, and pops only free space.
  - The WAIT-state write therefore never overflows.
- sample_ready outside WAIT: ignored, no write, no state change. This covers stale strobes after reset.
- enable deasserted while in REQ/WAIT: the outstanding request completes normally; no new request is issued afterwards.
- Pop side:
  - sample_out = mem[rd_ptr] combinationally; sample_valid = (count != 0).
  - sample_ack=1 with sample_valid=1: read pointer increments (wraps mod DEPTH), count decrements.
  - sample_ack=1 with count=0: no pointer or count change; underflow sets and stays set until reset.
- Simultaneous push (WAIT and sample_ready) and pop in the same cycle: both pointers advance, count unchanged.
  - With count=0, the pushed word is not poppable that cycle, so the ack counts as an underflow.
- fill_level equals count, registered, updated the cycle after the push/pop edge.
- Reset mid-operation (any state, including WAIT): immediate return to the reset values above. The FIFO contents are discarded.
- Arithmetic:
  - Pointers are ADDR_W bits and wrap naturally.
  - count is ADDR_W+1 bits, range 0..DEPTH; it never exceeds DEPTH and never goes negative.

Optional Feature:
- Macro: SAMPLE_REQUESTER_REQ_TIMEOUT_EN.
- When defined:
  - An internal counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without sample_ready: -> IDLE, no write, timeout_err sets (sticky until reset).
  - A fresh request follows per the normal IDLE rules.
  - A sample_ready arriving late after a timeout is ignored unless the FSM is in WAIT.
- When undefined:
  - No counter and no timeout_err port.
  - WAIT holds indefinitely until sample_ready.

Test Plan:
- Reset then enable=1, generator returns sample_ready 1 cycle after each pulse with values 0x0001..0x0004, no acks -> exactly 4 generate_next pulses 3 cycles apart; fill_level=4; no further pulses; sample_out=0x0001, sample_valid=1.
- From full FIFO, ack 4 consecutive cycles -> sample_out sequence 0x0001,0x0002,0x0003,0x0004; fill_level returns to 0; a new generate_next pulse appears within 1 cycle of count<4.
- Push in the same cycle as an ack with count=2 -> fill_level stays 2; pointers wrap correctly across index 3->0 after 6 total pushes; data order preserved.
- Ack with FIFO empty -> underflow=1 and held; fill_level stays 0; sample_ready pulsed in IDLE -> no write, fill_level 0.
- Assert reset while in WAIT, then sample_ready one cycle after reset release -> strobe ignored, fill_level=0, FSM restarts with a fresh pulse when enable=1.
- With SAMPLE_REQUESTER_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, generator never responds -> timeout_err=1 after 8 WAIT cycles; new generate_next pulse follows; fill_level remains 0.

Source files
------------

// File: rtl/sample_requester.sv
// sample_requester
//
// Consumer-side partner of the sine sample generator. Requests one sample at a
// time with a single-cycle generate_next pulse. Captures the returned sample
// when sample_ready strobes. Queues captured samples in a small FIFO, so the
// downstream audio output stage never waits on generator latency.
//
// Optional build macro: SAMPLE_REQUESTER_REQ_TIMEOUT_EN
//   When defined, a watchdog abandons a WAIT that lasts TIMEOUT_CYCLES cycles
//   and raises the sticky timeout_err output. In that case the TIMEOUT_CYCLES
//   parameter and the timeout_err port exist. When the macro is undefined,
//   WAIT holds until sample_ready arrives.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   enable         allows new requests while high
//   generate_next  one-cycle request pulse to the generator
//   sample_ready   generator strobe, sample_in valid this cycle
//   sample_in      sample from the generator
//   sample_out     FIFO head (first-word fall-through), qualified by sample_valid
//   sample_valid   FIFO non-empty
//   sample_ack     consumer pops the head this cycle
//   fill_level     FIFO occupancy, 0..DEPTH
//   underflow      sticky, ack seen while the FIFO was empty
//   timeout_err    sticky watchdog flag (only with the macro)
`timescale 1ns/1ps

module sample_requester #(
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 2
`ifdef SAMPLE_REQUESTER_REQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    output logic                generate_next,
    input  logic                sample_ready,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    input  logic                sample_ack,
    output logic [ADDR_W:0]     fill_level,
    output logic                underflow
`ifdef SAMPLE_REQUESTER_REQ_TIMEOUT_EN
    ,
    output logic                timeout_err
`endif
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                underflow_q, underflow_d;
    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic                push;
    logic                pop;

`ifdef SAMPLE_REQUESTER_REQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_err_q, timeout_err_d;
`endif

    // Request FSM. The space check in IDLE guarantees that the one outstanding
    // request always has a free slot, so the WAIT write can never overflow.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
`ifdef SAMPLE_REQUESTER_REQ_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable && (count_q < DEPTH_CNT)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
`ifdef SAMPLE_REQUESTER_REQ_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            WAIT: begin
                if (sample_ready) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
`ifdef SAMPLE_REQUESTER_REQ_TIMEOUT_EN
                // The counter holds the number of WAIT cycles already spent.
                // The last permitted cycle gives up without writing.
                else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping. An ack on an empty FIFO cannot pop, not even the word
    // that is being pushed in the same cycle. It is recorded as an underflow.
    always_comb begin
        pop         = sample_ack && (count_q != '0);
        wr_ptr_d    = push ? (wr_ptr_q + ADDR_W'(1)) : wr_ptr_q;
        rd_ptr_d    = pop  ? (rd_ptr_q + ADDR_W'(1)) : rd_ptr_q;
        underflow_d = underflow_q | (sample_ack && (count_q == '0));
        count_d     = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
`ifdef SAMPLE_REQUESTER_REQ_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
`ifdef SAMPLE_REQUESTER_REQ_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    // Storage is not reset. Resetting the pointers and count discards it.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    assign generate_next = (state_q == REQ);
    assign sample_out    = mem_q[rd_ptr_q];
    assign sample_valid  = (count_q != '0);
    assign fill_level    = count_q;
    assign underflow     = underflow_q;
`ifdef SAMPLE_REQUESTER_REQ_TIMEOUT_EN
    assign timeout_err   = timeout_err_q;
`endif

endmodule

// File: tb/tb_sample_requester.sv
// Testbench for sample_requester.
//
// The driver applies inputs just after each rising edge. It also advances a
// behavioural reference model: the requester phase, the FIFO occupancy and the
// sticky flags. Every sample it hands to the DUT is pushed into an expected-data
// queue. A separate monitor runs on the falling edge. It compares the outputs
// with the model and pops the queue whenever the DUT presents a popped word.
// Works with or without SAMPLE_REQUESTER_REQ_TIMEOUT_EN (TIMEOUT_CYCLES = 8).
`timescale 1ns/1ps

module tb_sample_requester;

    localparam int SAMPLE_W = 16;
    localparam int ADDR_W   = 2;
    localparam int DEPTH    = 1 << ADDR_W;
`ifdef SAMPLE_REQUESTER_REQ_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 8;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                generate_next;
    logic                sample_ready;
    logic [SAMPLE_W-1:0] sample_in;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid;
    logic                sample_ack;
    logic [ADDR_W:0]     fill_level;
    logic                underflow;
`ifdef SAMPLE_REQUESTER_REQ_TIMEOUT_EN
    logic                timeout_err;
`endif

`ifdef SAMPLE_REQUESTER_REQ_TIMEOUT_EN
    sample_requester #(
        .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .generate_next(generate_next),
        .sample_ready(sample_ready), .sample_in(sample_in), .sample_out(sample_out),
        .sample_valid(sample_valid), .sample_ack(sample_ack), .fill_level(fill_level),
        .underflow(underflow), .timeout_err(timeout_err)
    );
`else
    sample_requester #(
        .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .generate_next(generate_next),
        .sample_ready(sample_ready), .sample_in(sample_in), .sample_out(sample_out),
        .sample_valid(sample_valid), .sample_ack(sample_ack), .fill_level(fill_level),
        .underflow(underflow)
    );
`endif

    always #5 clk = ~clk;

    // Reference model state
    typedef enum {P_IDLE, P_REQ, P_WAIT} phase_t;
    phase_t              m_phase       = P_IDLE;
    int                  m_count       = 0;
    int                  m_wait_cycles = 0;
    bit                  m_underflow   = 1'b0;
    bit                  m_timeout     = 1'b0;
    logic [SAMPLE_W-1:0] exp_q[$];

    int checks   = 0;
    int errors   = 0;
    bit check_en = 1'b0;
    int cycle    = 0;
    int pulse_cycles[$];

    // Stimulus knobs (percent probabilities)
    int                  en_pct         = 100;
    int                  ack_pct        = 0;
    int                  rdy_pct        = 100;
    int                  stale_pct      = 0;
    bit                  seq_vals       = 1'b1;
    bit                  ack_only_valid = 1'b0;
    logic [SAMPLE_W-1:0] next_val       = 16'h0001;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit en, input bit rdy,
                                 input logic [SAMPLE_W-1:0] val, input bit ack);
        reset        = rst;
        enable       = en;
        sample_ready = rdy;
        sample_in    = val;
        sample_ack   = ack;
    endtask

    // Advance the model across one rising edge, using the inputs currently applied.
    task automatic stepCycle();
        bit     push;
        bit     pop;
        bit     uf;
        phase_t nxt;
        push = (m_phase == P_WAIT) && sample_ready;
        pop  = sample_ack && (m_count > 0);
        uf   = sample_ack && (m_count == 0);
        nxt  = m_phase;
        case (m_phase)
            P_IDLE: if (enable && m_count < DEPTH) nxt = P_REQ;
            P_REQ:  nxt = P_WAIT;
            P_WAIT: if (sample_ready) nxt = P_IDLE;
            default: nxt = P_IDLE;
        endcase
        @(posedge clk);
        #1;
        cycle++;
        if (generate_next === 1'b1) pulse_cycles.push_back(cycle);
        if (reset) begin
            m_phase       = P_IDLE;
            m_count       = 0;
            m_wait_cycles = 0;
            m_underflow   = 1'b0;
            m_timeout     = 1'b0;
            exp_q.delete();
        end else begin
            if (push) exp_q.push_back(sample_in);
            if (uf) m_underflow = 1'b1;
            m_count = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
`ifdef SAMPLE_REQUESTER_REQ_TIMEOUT_EN
            if (m_phase == P_WAIT && !sample_ready) begin
                m_wait_cycles++;
                if (m_wait_cycles == TIMEOUT_CYCLES) begin
                    nxt       = P_IDLE;
                    m_timeout = 1'b1;
                end
            end
`endif
            if (m_phase == P_REQ) m_wait_cycles = 0;
            m_phase = nxt;
        end
    endtask

    task automatic chooseInputs();
        bit                  en;
        bit                  rdy;
        bit                  ack;
        logic [SAMPLE_W-1:0] val;
        en = ($urandom_range(99) < en_pct);
        if (m_phase == P_WAIT) rdy = ($urandom_range(99) < rdy_pct);
        else                   rdy = ($urandom_range(99) < stale_pct);
        ack = ($urandom_range(99) < ack_pct);
        if (ack_only_valid && m_count == 0) ack = 1'b0;
        if (seq_vals) begin
            val = next_val;
            if (rdy && m_phase == P_WAIT) next_val = next_val + 16'h0001;
        end else begin
            val = SAMPLE_W'($urandom);
        end
        applyStimulus(1'b0, en, rdy, val, ack);
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            chooseInputs();
            stepCycle();
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("fill_level", fill_level, m_count);
            checkOutput("sample_valid", sample_valid, m_count != 0);
            checkOutput("underflow", underflow, m_underflow);
            checkOutput("generate_next", generate_next, m_phase == P_REQ);
`ifdef SAMPLE_REQUESTER_REQ_TIMEOUT_EN
            checkOutput("timeout_err", timeout_err, m_timeout);
`endif
            if (sample_ack === 1'b1 && sample_valid === 1'b1) begin
                checkOutput("scoreboard_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    checkOutput("sample_out", sample_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        bit found;

        // Reset values
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        stepCycle();
        check_en = 1'b1;
        checkOutput("reset_generate_next", generate_next, 0);
        checkOutput("reset_fill_level", fill_level, 0);
        checkOutput("reset_sample_valid", sample_valid, 0);
        checkOutput("reset_underflow", underflow, 0);

        // Fill with 1..4, generator answers on the first WAIT cycle, no acks
        $display("[TB] fill to full");
        pulse_cycles.delete();
        runCycles(20);
        checkOutput("fill_pulse_count", pulse_cycles.size(), 4);
        for (int i = 1; i < pulse_cycles.size(); i++) begin
            checkOutput("fill_pulse_spacing", pulse_cycles[i] - pulse_cycles[i-1], 3);
        end
        checkOutput("fill_full_level", fill_level, 4);
        checkOutput("fill_head", sample_out, 16'h0001);
        checkOutput("fill_head_valid", sample_valid, 1);

        // Pop four words while refilling, then drain with requests disabled
        $display("[TB] pop and drain");
        ack_pct = 100;
        ack_only_valid = 1'b1;
        runCycles(4);
        en_pct = 0;
        runCycles(16);
        checkOutput("drain_level", fill_level, 0);

        // Simultaneous push and pop at occupancy 2
        $display("[TB] push with pop");
        en_pct = 100;
        ack_pct = 0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_count == 2 && m_phase == P_WAIT) begin
                found = 1'b1;
                break;
            end
            chooseInputs();
            stepCycle();
        end
        checkOutput("reach_level2_wait", found, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, next_val, 1'b1);
        next_val = next_val + 16'h0001;
        stepCycle();
        checkOutput("push_pop_level", fill_level, 2);
        en_pct = 0;
        ack_pct = 100;
        runCycles(16);
        checkOutput("push_pop_drained", fill_level, 0);

        // Underflow and a stale strobe in IDLE
        $display("[TB] underflow and stale strobe");
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        stepCycle();
        checkOutput("underflow_set", underflow, 1);
        checkOutput("underflow_level", fill_level, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        stepCycle();
        checkOutput("stale_level", fill_level, 0);
        checkOutput("underflow_sticky", underflow, 1);

        // Reset while waiting, then a strobe right after reset release
        $display("[TB] reset in WAIT");
        ack_pct = 0;
        ack_only_valid = 1'b0;
        en_pct = 100;
        rdy_pct = 0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_phase == P_WAIT) begin
                found = 1'b1;
                break;
            end
            chooseInputs();
            stepCycle();
        end
        checkOutput("reach_wait", found, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        stepCycle();
        checkOutput("rst_wait_underflow", underflow, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234, 1'b0);
        stepCycle();
        checkOutput("rst_stale_level", fill_level, 0);
        checkOutput("rst_fresh_pulse", generate_next, 1);
        rdy_pct = 100;
        runCycles(6);

`ifdef SAMPLE_REQUESTER_REQ_TIMEOUT_EN
        // Generator never answers
        $display("[TB] watchdog timeout");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        stepCycle();
        rdy_pct = 0;
        stale_pct = 0;
        pulse_cycles.delete();
        runCycles(14);
        checkOutput("timeout_flag", timeout_err, 1);
        checkOutput("timeout_level", fill_level, 0);
        checkOutput("timeout_repulse", pulse_cycles.size() >= 2, 1);
        rdy_pct = 100;
        runCycles(6);
`endif

        // Randomized traffic with occasional resets
        $display("[TB] random traffic");
        en_pct = 80;
        ack_pct = 40;
        rdy_pct = 50;
        stale_pct = 10;
        seq_vals = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(99) == 0) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
            else chooseInputs();
            stepCycle();
        end
        en_pct = 0;
        ack_pct = 100;
        rdy_pct = 100;
        stale_pct = 0;
        runCycles(20);
        checkOutput("final_level", fill_level, 0);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
